// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: button synchronise/debounce, mode FSM,
// 1 Hz count-enable tick, counter-clear pulse and display-freeze select.
module stopwatch_ctrl #(
    parameter int unsigned TICK_DIV     = 12000000,
    parameter int unsigned DEBOUNCE_CYC = 120000,
    parameter int unsigned CNT_W        = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_ss,
    input  logic       btn_lr,
    output logic       run,
    output logic       tick,
    output logic       clr,
    output logic       freeze,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        LAP   = 2'b10,
        PAUSE = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

    // Index 0 is start/stop, index 1 is lap/reset.
    logic [1:0] btn_raw;
    logic [1:0] sync1;
    logic [1:0] sync2;
    logic [1:0] deb;
    logic [1:0] press;

    assign btn_raw = {btn_lr, btn_ss};

    for (genvar g = 0; g < 2; g++) begin : g_btn
        logic [CNT_W-1:0] db_cnt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync1[g] <= 1'b0;
                sync2[g] <= 1'b0;
                deb[g]   <= 1'b0;
                press[g] <= 1'b0;
                db_cnt   <= '0;
            end else begin
                sync1[g] <= btn_raw[g];
                sync2[g] <= sync1[g];
                press[g] <= 1'b0;
                if (sync2[g] == deb[g]) begin
                    db_cnt <= '0;
                end else if (db_cnt == DB_LAST) begin
                    // Level accepted on the DEBOUNCE_CYC-th differing sample;
                    // only the rising acceptance produces a press.
                    db_cnt   <= '0;
                    deb[g]   <= sync2[g];
                    press[g] <= sync2[g];
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end
        end
    end

    wire press_ss = press[0];
    wire press_lr = press[1];

    state_t           state_q;
    state_t           state_d;
    logic             clr_q;
    logic             clr_d;
    logic [CNT_W-1:0] presc;

    always_comb begin
        state_d = state_q;
        clr_d   = 1'b0;
        // Start/stop is tested first so it wins a simultaneous press.
        case (state_q)
            IDLE: begin
                if (press_ss) begin
                    state_d = RUN;
                end else if (press_lr) begin
                    clr_d = 1'b1;
                end
            end
            RUN: begin
                if (press_ss) begin
                    state_d = PAUSE;
                end else if (press_lr) begin
                    state_d = LAP;
                end
            end
            LAP: begin
                if (press_ss) begin
                    state_d = PAUSE;
                end else if (press_lr) begin
                    state_d = RUN;
                end
            end
            PAUSE: begin
                if (press_ss) begin
                    state_d = RUN;
                end else if (press_lr) begin
                    state_d = IDLE;
                    clr_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
        end
    end

    // Prescaler holds while not running so pause/resume keeps sub-second phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (clr_d) begin
            presc <= '0;
        end else if (run) begin
            if (presc == TICK_LAST) begin
                presc <= '0;
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

    assign run    = (state_q == RUN) || (state_q == LAP);
    assign freeze = (state_q == LAP);
    assign tick   = run && (presc == TICK_LAST);
    assign clr    = clr_q;
    assign state  = state_q;

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Control sequencer for the stopwatch core. It synchronises and debounces two raw push-buttons and runs the stopwatch mode FSM (idle / run / lap-hold / pause). It generates the 1 Hz count-enable tick, the counter-clear pulse and the display-freeze select consumed by the stopwatch datapath and the 7-seg path. It sits between the TinyTapeout ui_in pins and the stopwatch counter.

Parameters:
TICK_DIV, 12000000, clk cycles per count tick (1 s at 12 MHz); must be >= 2
DEBOUNCE_CYC, 120000, consecutive stable synchronised samples required to accept a new button level (10 ms); must be >= 1
CNT_W, 24, width of the prescaler and debounce counters; must hold TICK_DIV-1 and DEBOUNCE_CYC

Ports:
clk  input  1  global clock
rst_n  input  1  asynchronous, active-low reset
btn_ss  input  1  raw start/stop button, active-high, asynchronous to clk, may bounce
btn_lr  input  1  raw lap/reset button, active-high, asynchronous to clk, may bounce
run  output  1  count enable level; high in RUN and LAP
tick  output  1  one-cycle count pulse, at most one per TICK_DIV cycles, only while run=1
clr  output  1  one-cycle synchronous clear pulse for the stopwatch counters
freeze  output  1  high in LAP; the display holds its latched value
state  output  2  FSM state: 00 IDLE, 01 RUN, 10 LAP, 11 PAUSE

Behaviour:
- Reset (rst_n=0, async): state=IDLE; run, tick, clr and freeze = 0; synchronisers, debounced levels, debounce counters and prescaler = 0. Reset never produces a clr pulse.
- Input path, per button:
  - 2-flop synchroniser.
  - Debounce counter increments while the synchronised level differs from the debounced level, and zeroes when they match.
  - When the counter reaches DEBOUNCE_CYC, the debounced level flips and the counter zeroes.
  - A press pulse (1 cycle) fires on the debounced 0->1 transition only. Releases are debounced but produce no pulse.
  - A held button produces exactly one press. Glitches shorter than DEBOUNCE_CYC cycles are ignored.
- Latency: btn rises and is held stable → state output changes exactly DEBOUNCE_CYC+3 clock edges after the first edge that samples it high.
- FSM (evaluated on the press pulse; outputs registered):
  - IDLE: ss→RUN. lr→stay IDLE and pulse clr.
  - RUN: ss→PAUSE. lr→LAP.
  - LAP: ss→PAUSE (freeze drops). lr→RUN (freeze drops; display resumes live).
  - PAUSE: ss→RUN (resume). lr→IDLE and pulse clr.
- Simultaneous press pulses: ss wins and the lr press is discarded.
- run = 1 in RUN and LAP. freeze = 1 in LAP only. Counting continues during LAP.
- clr: high for exactly the one cycle after the edge that enters IDLE via lr. Asserting clr zeroes the prescaler in the same edge.
- Prescaler:
  - Counts only while run=1, range 0..TICK_DIV-1, then wraps to 0.
  - tick=1 in the cycle where prescaler==TICK_DIV-1 and run=1.
  - Holds its value in PAUSE, so sub-second phase is preserved across pause/resume.
  - Zeroed on clr.
  - From IDLE→RUN with prescaler=0, the first tick comes TICK_DIV cycles after run rises.
- tick and clr are never high in the same cycle.
- Reset mid-operation: returns immediately to the reset values above; any partial debounce is lost.

Test Plan:
(DEBOUNCE_CYC=4, TICK_DIV=10 for all scenarios)
1. Reset, hold btn_ss high 20 cycles → state 00→01 exactly 7 edges after first sampled-high edge; one transition only; tick every 10 cycles, first tick 10 cycles after run rises.
2. btn_ss pulses of 3 cycles high and 3 cycles low, repeated 10× → no state change. Then a 6-cycle hold → one transition.
3. RUN for 25 cycles, press ss (PAUSE) for 37 cycles, press ss (RUN) → tick spacing across the pause accounts for exactly 10 running cycles (prescaler retained); no tick while run=0.
4. RUN, press lr → state=10, freeze=1, run=1, ticks continue. Press lr → state=01, freeze=0. Press lr, then ss → state=11, freeze=0.
5. PAUSE, press lr → state=00 and clr high exactly 1 cycle. Next ss → first tick 10 cycles after run rises. In IDLE, press lr → clr pulses, state stays 00.
6. Both buttons raised in the same cycle from RUN → state=11, lr ignored. Also assert rst_n=0 mid-debounce while in LAP → all outputs 0 and state=00 asynchronously; no clr.
